// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scanner slice.
// Consumed by truth_table_scanner and tt_settle_cnt.
package tt_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int SETTLE_W = 4;

    function automatic int ones_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/tt_settle_cnt.sv
// Loadable settle down-counter. The zero flag marks the final count, meaning
// the decrement in the current cycle brings the counter to zero.
module tt_settle_cnt
    import tt_scan_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                dec,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                zero
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - SETTLE_W'(1);
        end
    end

    // Flag is decoded from the count alone so the FSM can use it without a comb loop.
    assign zero = (cnt == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all 2^N_IN input vectors into a boolean FUT and captures its minterm mask.
// Optional expected-mask comparison is built when TT_EXPECT_CHECK_EN is defined.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [N_IN-1:0]           vec_out,
    input  logic                      f_in,
    output logic                      busy,
    output logic                      done,
    output logic [2**N_IN-1:0]        mask,
    output logic [ones_w(N_IN)-1:0]   ones
`ifdef TT_EXPECT_CHECK_EN
    ,
    input  logic [2**N_IN-1:0]        expect_mask,
    output logic                      mismatch
`endif
);

    localparam int              OW       = ones_w(N_IN);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    state_t state, state_nx;
    logic   cnt_load, cnt_dec, cnt_zero;
    logic   scan_clr, vec_inc, capture;

    tt_settle_cnt u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (SETTLE_W'(SETTLE)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        scan_clr = 1'b0;
        vec_inc  = 1'b0;
        capture  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    scan_clr = 1'b1;
                    cnt_load = 1'b1;
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                busy    = 1'b1;
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                busy    = 1'b1;
                capture = 1'b1;
                if (vec_out == VEC_LAST) begin
                    state_nx = DONE;
                end else begin
                    vec_inc  = 1'b1;
                    cnt_load = 1'b1;
                    state_nx = DRIVE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_out <= '0;
            mask    <= '0;
            ones    <= '0;
        end else if (scan_clr) begin
            vec_out <= '0;
            mask    <= '0;
            ones    <= '0;
        end else begin
            if (capture) begin
                mask[vec_out] <= f_in;
                ones          <= ones + OW'(f_in);
            end
            if (vec_inc) begin
                vec_out <= vec_out + N_IN'(1);
            end
        end
    end

`ifdef TT_EXPECT_CHECK_EN
    // Verdict is latched as the DONE cycle ends, once the last minterm is in mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if (scan_clr) begin
            mismatch <= 1'b0;
        end else if (state == DONE) begin
            mismatch <= (mask != expect_mask);
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3)
// driven by table-defined FUTs and checked against a cycle/result reference model.
module tb_truth_table_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b;
    logic [2:0] vec_a, vec_b;
    logic       f_a, f_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [7:0] mask_a, mask_b;
    logic [3:0] ones_a, ones_b;
    logic [7:0] tt_a, tt_b;
`ifdef TT_EXPECT_CHECK_EN
    logic [7:0] exp_a, exp_b;
    logic       mis_a, mis_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // FUT is a lookup table indexed by the applied vector.
    assign f_a = tt_a[vec_a];
    assign f_b = tt_b[vec_b];

    truth_table_scanner #(.N_IN(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .vec_out(vec_a), .f_in(f_a),
        .busy(busy_a), .done(done_a), .mask(mask_a), .ones(ones_a)
`ifdef TT_EXPECT_CHECK_EN
        , .expect_mask(exp_a), .mismatch(mis_a)
`endif
    );

    truth_table_scanner #(.N_IN(3), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .vec_out(vec_b), .f_in(f_b),
        .busy(busy_b), .done(done_b), .mask(mask_b), .ones(ones_b)
`ifdef TT_EXPECT_CHECK_EN
        , .expect_mask(exp_b), .mismatch(mis_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) start_a = v; else start_b = v;
    endtask

    // One scan on instance d; hold keeps start high past DONE, poke pulses start mid-scan.
    task automatic scan(input int d, input logic [7:0] tbl, input bit hold, input bit poke);
        int         s, total, bad_busy, bad_done, bad_vec;
        logic       b, dn;
        logic [2:0] v;
        logic [7:0] m;
        logic [3:0] o;
        bit         seen;
`ifdef TT_EXPECT_CHECK_EN
        logic [7:0] ex;
        logic       mi;
`endif
        s        = (d == 0) ? 1 : 3;
        total    = 8 * (s + 1);
        bad_busy = 0;
        bad_done = 0;
        bad_vec  = 0;
        @(negedge clk);
        if (d == 0) tt_a = tbl; else tt_b = tbl;
`ifdef TT_EXPECT_CHECK_EN
        ex = $urandom_range(0, 1) ? tbl : (tbl ^ 8'($urandom_range(1, 255)));
        if (d == 0) exp_a = ex; else exp_b = ex;
`endif
        set_start(d, 1'b1);
        for (int cyc = 1; cyc <= total + 2; cyc++) begin
            @(negedge clk);
            b  = d ? busy_b : busy_a;
            dn = d ? done_b : done_a;
            v  = d ? vec_b  : vec_a;
            if (b  !== (cyc <= total))       bad_busy++;
            if (dn !== (cyc == total + 1))   bad_done++;
            if (v  !== ((cyc <= total) ? 3'((cyc - 1) / (s + 1)) : 3'd7)) bad_vec++;
`ifdef TT_EXPECT_CHECK_EN
            if (cyc == 1) check("mismatch_clr", d ? mis_b : mis_a, 0);
`endif
            if (cyc == 1 && !hold) set_start(d, 1'b0);
            if (poke && cyc == 3) set_start(d, 1'b1);
            if (poke && cyc == 4) set_start(d, 1'b0);
        end
        check("busy_window", bad_busy, 0);
        check("done_pulse",  bad_done, 0);
        check("vec_steps",   bad_vec,  0);
        m = d ? mask_b : mask_a;
        o = d ? ones_b : ones_a;
        check("mask", m, tbl);
        check("ones", o, $countones(tbl));
`ifdef TT_EXPECT_CHECK_EN
        mi = d ? mis_b : mis_a;
        check("mismatch", mi, (tbl != ex));
`endif
        if (hold) begin
            @(negedge clk);
            check("restart_busy", d ? busy_b : busy_a, 1);
            check("restart_clr", d ? mask_b : mask_a, 0);
            set_start(d, 1'b0);
            seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge clk);
                seen = d ? done_b : done_a;
            end
            check("restart_done", seen, 1);
            check("restart_mask", d ? mask_b : mask_a, tbl);
        end else begin
            if (d == 0) tt_a = ~tbl; else tt_b = ~tbl;
            repeat (3) @(negedge clk);
            check("mask_hold", d ? mask_b : mask_a, tbl);
        end
    endtask

    initial begin
        logic [7:0] r;
        bit         seen;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        tt_a    = 8'h00;
        tt_b    = 8'h00;
`ifdef TT_EXPECT_CHECK_EN
        exp_a   = 8'h00;
        exp_b   = 8'h00;
`endif
        repeat (3) @(negedge clk);
        check("reset_a", {vec_a, busy_a, done_a, mask_a, ones_a}, 0);
        check("reset_b", {vec_b, busy_b, done_b, mask_b, ones_b}, 0);
        rst_n = 1'b1;

        // s = ~x & ~y & z is minterm 1
        scan(0, 8'h02, 1'b0, 1'b0);
        scan(1, 8'h02, 1'b0, 1'b0);
        scan(0, 8'hFF, 1'b0, 1'b0);
        scan(1, 8'h00, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            r = 8'($urandom);
            scan(0, r, 1'b0, 1'b0);
            r = 8'($urandom);
            scan(1, r, 1'b0, 1'b0);
        end
        scan(0, 8'($urandom), 1'b1, 1'b0);
        scan(1, 8'($urandom), 1'b0, 1'b1);
        scan(0, 8'hA5, 1'b0, 1'b1);

        // Abort a scan with reset at cycle 7, then confirm no stray done.
        @(negedge clk);
        tt_a    = 8'h3C;
        start_a = 1'b1;
        repeat (7) @(negedge clk);
        start_a = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("abort_reset", {vec_a, busy_a, done_a, mask_a, ones_a}, 0);
        repeat (2) @(negedge clk);
        check("abort_hold", {vec_a, busy_a, done_a, mask_a, ones_a}, 0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a || busy_a) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        scan(0, 8'h02, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
